// File: rtl/ecg_pkg.sv
// Types shared along the ECG filter chain: the Q15 sample type used by the FIR
// and the R-peak detector, plus the detector's FSM states.
package ecg_pkg;

  localparam int ECG_DATA_W = 16;

  typedef logic signed [ECG_DATA_W-1:0] q15_t;

  typedef enum logic [1:0] {
    SEARCH  = 2'd0,
    TRACK   = 2'd1,
    REFRACT = 2'd2
  } ecg_state_e;

  // Bits needed for a counter that must represent 0..max_val.
  function automatic int cnt_width(input int max_val);
    return (max_val < 2) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/ecg_r_peak_detector_if.sv
// Filtered-sample stream into the R-peak detector and the per-beat event out of it.
interface ecg_r_peak_detector_if
  import ecg_pkg::*;
#(
  parameter int DATA_W = ECG_DATA_W,
  parameter int RR_W   = 16
);

  logic signed [DATA_W-1:0] sample_in;
  logic                     sample_valid;
  logic signed [DATA_W-1:0] threshold;
  logic                     peak_valid;
  logic signed [DATA_W-1:0] peak_amp;
  logic [RR_W-1:0]          rr_interval;
  logic                     first_peak;

  modport master (
    output sample_in,
    output sample_valid,
    output threshold,
    input  peak_valid,
    input  peak_amp,
    input  rr_interval,
    input  first_peak
  );

  modport slave (
    input  sample_in,
    input  sample_valid,
    input  threshold,
    output peak_valid,
    output peak_amp,
    output rr_interval,
    output first_peak
  );

endinterface

// File: rtl/sat_counter.sv
// Saturating up-counter: synchronous clear beats load beats increment; it holds at
// all-ones instead of wrapping.
module sat_counter #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         clear,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         en,
  output logic [W-1:0] count
);

  // NOTE: state is updated with <= so every flop samples pre-edge values, which keeps
  // simulation in step with the synthesized registers.
  always_ff @(posedge clk) begin
    if (reset || clear) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (en && (count != '1)) begin
      count <= count + W'(1);
    end
  end

endmodule

// File: rtl/ecg_r_peak_detector.sv
// R-peak detector: threshold crossing opens a tracking window that follows the local
// maximum, then a refractory window; each beat yields one registered event.
module ecg_r_peak_detector
  import ecg_pkg::*;
#(
  parameter int DATA_W            = ECG_DATA_W,
  parameter int RR_W              = 16,
  parameter int REFRACT_SAMPLES   = 50,
  parameter int MAX_TRACK_SAMPLES = 40
) (
  input logic                  clk,
  input logic                  reset,
  ecg_r_peak_detector_if.slave bus
);

  localparam int TRACK_W = cnt_width(MAX_TRACK_SAMPLES);
  localparam int REFR_W  = cnt_width(REFRACT_SAMPLES);

  ecg_state_e               state;
  ecg_state_e               state_nxt;
  logic signed [DATA_W-1:0] max_amp;
  logic signed [DATA_W-1:0] max_amp_nxt;
  logic [RR_W-1:0]          rr_cand;
  logic [RR_W-1:0]          rr_cand_nxt;
  logic                     first_armed;

  logic [RR_W-1:0]          sp_cnt;
  logic [RR_W-1:0]          sp_inc;
  logic [RR_W-1:0]          sp_load_val;
  logic                     sp_load;
  logic [TRACK_W-1:0]       track_cnt;
  logic                     track_load;
  logic                     track_en;
  logic [REFR_W-1:0]        refr_cnt;
  logic                     refr_clear;
  logic                     refr_en;

  logic                     valid;
  logic                     above_thr;
  logic                     above_max;
  logic                     emit;

  logic                     peak_valid_q;
  logic signed [DATA_W-1:0] peak_amp_q;
  logic [RR_W-1:0]          rr_interval_q;
  logic                     first_peak_q;

  assign valid     = bus.sample_valid;
  assign above_thr = bus.sample_in > bus.threshold;
  assign above_max = bus.sample_in > max_amp;

  // Since-peak count including the current sample; this is a sample's "position".
  assign sp_inc = (sp_cnt == '1) ? sp_cnt : sp_cnt + RR_W'(1);

  sat_counter #(.W(RR_W)) u_sp_cnt (
    .clk      (clk),
    .reset    (reset),
    .clear    (1'b0),
    .load     (sp_load),
    .load_val (sp_load_val),
    .en       (valid),
    .count    (sp_cnt)
  );

  sat_counter #(.W(TRACK_W)) u_track_cnt (
    .clk      (clk),
    .reset    (reset),
    .clear    (1'b0),
    .load     (track_load),
    .load_val (TRACK_W'(1)),
    .en       (track_en),
    .count    (track_cnt)
  );

  sat_counter #(.W(REFR_W)) u_refr_cnt (
    .clk      (clk),
    .reset    (reset),
    .clear    (refr_clear),
    .load     (1'b0),
    .load_val ('0),
    .en       (refr_en),
    .count    (refr_cnt)
  );

  always_comb begin
    // NOTE: every signal written here gets a default first, so no path leaves one
    // unassigned and no latch is inferred.
    state_nxt   = state;
    max_amp_nxt = max_amp;
    rr_cand_nxt = rr_cand;
    sp_load     = 1'b0;
    sp_load_val = '0;
    track_load  = 1'b0;
    track_en    = 1'b0;
    refr_clear  = 1'b0;
    refr_en     = 1'b0;
    emit        = 1'b0;

    if (valid) begin
      unique case (state)
        SEARCH: begin
          if (above_thr) begin
            max_amp_nxt = bus.sample_in;
            rr_cand_nxt = sp_inc;
            track_load  = 1'b1;
            state_nxt   = TRACK;
          end
        end
        TRACK: begin
          track_en = 1'b1;
          if (above_max) begin
            max_amp_nxt = bus.sample_in;
            rr_cand_nxt = sp_inc;
          end
          // The max update above is already folded in when the window closes.
          if (!above_thr || (track_cnt >= TRACK_W'(MAX_TRACK_SAMPLES))) begin
            emit        = 1'b1;
            state_nxt   = REFRACT;
            refr_clear  = 1'b1;
            sp_load     = 1'b1;
            sp_load_val = sp_inc - rr_cand_nxt;
          end
        end
        REFRACT: begin
          refr_en = 1'b1;
          if (refr_cnt >= REFR_W'(REFRACT_SAMPLES - 1)) begin
            state_nxt = SEARCH;
          end
        end
        default: state_nxt = SEARCH;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= SEARCH;
    end else begin
      state <= state_nxt;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      max_amp       <= '0;
      rr_cand       <= '0;
      first_armed   <= 1'b1;
      peak_valid_q  <= 1'b0;
      peak_amp_q    <= '0;
      rr_interval_q <= '0;
      first_peak_q  <= 1'b0;
    end else begin
      max_amp      <= max_amp_nxt;
      rr_cand      <= rr_cand_nxt;
      peak_valid_q <= emit;
      if (emit) begin
        peak_amp_q    <= max_amp_nxt;
        first_peak_q  <= first_armed;
        first_armed   <= 1'b0;
        // A saturated since-peak count means the true interval is unknown.
        if (first_armed) begin
          rr_interval_q <= '0;
        end else if (sp_inc == '1) begin
          rr_interval_q <= '1;
        end else begin
          rr_interval_q <= rr_cand_nxt;
        end
      end
    end
  end

  assign bus.peak_valid  = peak_valid_q;
  assign bus.peak_amp    = peak_amp_q;
  assign bus.rr_interval = rr_interval_q;
  assign bus.first_peak  = first_peak_q;

endmodule

// File: tb/tb_ecg_r_peak_detector.sv
// Directed bench: dut_a uses the default windows, dut_b a 4-sample refractory window.
// Both see the same stream; a monitor logs each peak event with its sample index.
module tb_ecg_r_peak_detector;
  import ecg_pkg::*;

  localparam int RR_W = 16;

  logic clk   = 1'b0;
  logic reset = 1'b1;
  q15_t sample = '0;
  logic valid  = 1'b0;
  q15_t thr    = 16'sd1000;
  int   idx    = 0;

  int n_checks = 0;
  int n_fail   = 0;

  int              a_cnt = 0, a_idx = 0, b_cnt = 0, b_idx = 0;
  q15_t            a_amp = '0, b_amp = '0;
  logic [RR_W-1:0] a_rr = '0, b_rr = '0;
  logic            a_first = 1'b0, b_first = 1'b0;

  always #5 clk = ~clk;

  ecg_r_peak_detector_if #(.DATA_W(ECG_DATA_W), .RR_W(RR_W)) bus_a ();
  ecg_r_peak_detector_if #(.DATA_W(ECG_DATA_W), .RR_W(RR_W)) bus_b ();

  assign bus_a.sample_in    = sample;
  assign bus_a.sample_valid = valid;
  assign bus_a.threshold    = thr;
  assign bus_b.sample_in    = sample;
  assign bus_b.sample_valid = valid;
  assign bus_b.threshold    = thr;

  ecg_r_peak_detector dut_a (
    .clk   (clk),
    .reset (reset),
    .bus   (bus_a)
  );

  ecg_r_peak_detector #(.REFRACT_SAMPLES(4), .MAX_TRACK_SAMPLES(40)) dut_b (
    .clk   (clk),
    .reset (reset),
    .bus   (bus_b)
  );

  // Inputs change on negedge; outputs are logged 2 ns after each posedge.
  always @(posedge clk) begin
    #2;
    if (reset) begin
      a_cnt = 0;
      b_cnt = 0;
    end else begin
      if (bus_a.peak_valid) begin
        a_cnt++;
        a_amp   = bus_a.peak_amp;
        a_rr    = bus_a.rr_interval;
        a_first = bus_a.first_peak;
        a_idx   = idx;
      end
      if (bus_b.peak_valid) begin
        b_cnt++;
        b_amp   = bus_b.peak_amp;
        b_rr    = bus_b.rr_interval;
        b_first = bus_b.first_peak;
        b_idx   = idx;
      end
    end
  end

  task automatic check(input string tag, input logic signed [63:0] obs,
                       input logic signed [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
    end
  endtask

  task automatic send(input int v);
    @(negedge clk);
    sample = q15_t'(v);
    valid  = 1'b1;
    idx++;
  endtask

  // Idle cycles carry a large value that must be ignored.
  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      sample = 16'sd30000;
      valid  = 1'b0;
    end
  endtask

  task automatic gsend(input int v, input bit gapped);
    send(v);
    if (gapped) idle(2);
  endtask

  task automatic zeros(input int n, input bit gapped);
    for (int i = 0; i < n; i++) gsend(0, gapped);
  endtask

  // Four-sample bump with its maximum on the second sample.
  task automatic bump(input bit gapped);
    gsend(1200, gapped);
    gsend(3000, gapped);
    gsend(2500, gapped);
    gsend(800, gapped);
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    valid = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    idx   = 0;
  endtask

  initial begin
    repeat (3) @(negedge clk);
    reset = 1'b0;
    idle(1);
    check("reset_peak_valid", bus_a.peak_valid, 0);
    check("reset_peak_amp", bus_a.peak_amp, 0);
    check("reset_rr", bus_a.rr_interval, 0);
    check("reset_first", bus_a.first_peak, 0);

    // Single bump, first peak: max 3000 at index 4, terminates on index 6.
    send(0);
    send(500);
    bump(1'b0);
    idle(1);
    check("t1_count", a_cnt, 1);
    check("t1_amp", a_amp, 3000);
    check("t1_first", a_first, 1);
    check("t1_rr", a_rr, 0);
    check("t1_latency_idx", a_idx, 6);

    zeros(196, 1'b0);
    idle(1);
    check("hold_peak_valid", bus_a.peak_valid, 0);
    check("hold_amp", bus_a.peak_amp, 3000);
    check("hold_first", bus_a.first_peak, 1);
    check("hold_count", a_cnt, 1);

    // Periodic beats: maxima at 204 and 404.
    bump(1'b0);
    idle(1);
    check("t2_count", a_cnt, 2);
    check("t2_rr", a_rr, 200);
    check("t2_first", a_first, 0);
    check("t2_amp", a_amp, 3000);
    check("t2_idx", a_idx, 206);
    zeros(196, 1'b0);
    bump(1'b0);
    idle(1);
    check("t2b_count", a_cnt, 3);
    check("t2b_rr", a_rr, 200);
    check("t2b_idx", a_idx, 406);

    // Gapped valid 1,0,0,1: maxima at 604 and 804.
    zeros(196, 1'b1);
    bump(1'b1);
    check("t5_count", a_cnt, 4);
    check("t5_rr", a_rr, 200);
    check("t5_first", a_first, 0);
    check("t5_idx", a_idx, 606);
    zeros(196, 1'b1);
    bump(1'b1);
    check("t5b_count", a_cnt, 5);
    check("t5b_rr", a_rr, 200);
    check("t5b_idx", a_idx, 806);

    // Refractory suppression on dut_b (4 samples): spikes 3 and 4 after termination.
    do_reset();
    bump(1'b0);
    send(0);
    send(0);
    send(1500);
    send(1500);
    send(0);
    send(0);
    idle(1);
    check("t3_count", b_cnt, 1);
    check("t3_amp", b_amp, 3000);
    check("t3_first", b_first, 1);
    check("t3_idx", b_idx, 4);
    bump(1'b0);
    idle(1);
    check("t3b_count", b_cnt, 2);
    check("t3b_rr", b_rr, 10);
    check("t3b_first", b_first, 0);
    check("t3b_idx", b_idx, 14);
    zeros(4, 1'b0);
    send(1500);
    send(0);
    idle(1);
    check("t3c_count", b_cnt, 3);
    check("t3c_amp", b_amp, 1500);
    check("t3c_rr", b_rr, 7);
    check("t3c_idx", b_idx, 20);

    // Forced emit: enter on index 2, 40th TRACK sample is index 42.
    do_reset();
    send(0);
    repeat (40) send(2000);
    idle(1);
    check("t4_no_early_peak", a_cnt, 0);
    send(2000);
    idle(1);
    check("t4_count", a_cnt, 1);
    check("t4_amp", a_amp, 2000);
    check("t4_first", a_first, 1);
    check("t4_idx", a_idx, 42);

    // Equal to threshold: never enters, but does terminate.
    do_reset();
    repeat (3) send(1000);
    idle(1);
    check("eq_no_entry", a_cnt, 0);
    send(1001);
    send(1000);
    idle(1);
    check("eq_count", a_cnt, 1);
    check("eq_amp", a_amp, 1001);
    check("eq_idx", a_idx, 5);

    // Reset mid-TRACK: refractory ends after index 55, bump enters at 56.
    zeros(50, 1'b0);
    send(1200);
    send(3000);
    do_reset();
    idle(1);
    check("t6_peak_valid", bus_a.peak_valid, 0);
    check("t6_amp", bus_a.peak_amp, 0);
    check("t6_rr", bus_a.rr_interval, 0);
    check("t6_first", bus_a.first_peak, 0);
    zeros(10, 1'b0);
    bump(1'b0);
    idle(1);
    check("t6b_count", a_cnt, 1);
    check("t6b_amp", a_amp, 3000);
    check("t6b_first", a_first, 1);
    check("t6b_rr", a_rr, 0);
    check("t6b_idx", a_idx, 14);

    // Negative threshold: signed comparisons.
    do_reset();
    thr = -16'sd100;
    send(-200);
    send(50);
    send(-150);
    idle(1);
    check("neg_count", a_cnt, 1);
    check("neg_amp", a_amp, 50);
    check("neg_idx", a_idx, 3);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
